match_sequencer: RTL and testbench
==================================

Name: match_sequencer

Overview:
- Round/match controller for the Bulls & Cows game.
- Sits between the player confirm button, the game core's win pulses and the score/display path.
- Starts each round with a restart pulse to the game core and alternates which player sets the secret.
- Counts round wins and holds a result banner between rounds; declares a match winner when a player reaches WIN_TARGET.

Parameters:
- WIN_TARGET, 3: round wins needed to take the match (1..2^SCORE_W-1).
- HOLD_CYCLES, 100000000: cycles the result banner is held between rounds (1 s at 100 MHz). Minimum 1.
- SCORE_W, 4: width of each score counter.
- ROUND_TIMEOUT, 3000000000: maximum round length in cycles. Used only with MATCH_TIMEOUT_EN.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- ssl_pulse, input, 1: one-cycle confirm pulse, already debounced and edge-detected upstream.
- p1_win, input, 1: one-cycle pulse from the game core when player 1 wins a round.
- p2_win, input, 1: one-cycle pulse from the game core when player 2 wins a round.
- round_rst, output, 1: one-cycle pulse that restarts the game core.
- first_player, output, 1: 0 = P1 sets the secret this round; 1 = P2 sets it.
- p1_score, output, SCORE_W: P1 round wins in the current match.
- p2_score, output, SCORE_W: P2 round wins in the current match.
- banner_en, output, 1: 1 = display shows the result banner instead of game digits.
- round_winner, output, 1: winner of the last round (0 = P1, 1 = P2). Valid while banner_en = 1.
- match_over, output, 1: high while in MATCH_END.
- match_winner, output, 1: match winner (0 = P1, 1 = P2). Valid while match_over = 1.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-high, and wins over every other input on that edge.
- Reset values: state = IDLE; round_rst = 0; first_player = 0; both scores = 0; banner_en = 0; round_winner = 0; match_over = 0; match_winner = 0; hold and timeout counters = 0.
- Outputs: all registered; no combinational input-to-output paths.
- State machine: IDLE, ROUND, ROUND_END, MATCH_END.
- IDLE:
  - ssl_pulse at edge N -> round_rst = 1 during cycle N+1 only; state = ROUND at N+1.
  - p1_win/p2_win are ignored.
- ROUND:
  - Exactly one of p1_win/p2_win at edge N -> at N+1: that player's score increments, round_winner is set, banner_en = 1, hold counter loaded with HOLD_CYCLES-1, state = ROUND_END.
  - p1_win and p2_win in the same cycle -> treated as void: no score change, state stays ROUND, no round_rst.
  - ssl_pulse is ignored.
- ROUND_END:
  - Hold counter decrements each cycle. Win pulses and ssl_pulse are ignored.
  - On the cycle the counter reads 0, if the updated score equals WIN_TARGET -> state = MATCH_END next cycle; match_over = 1; match_winner = round_winner; banner_en stays 1.
  - Otherwise -> banner_en = 0; first_player toggles; round_rst pulses for one cycle; state = ROUND.
  - Banner therefore asserts for exactly HOLD_CYCLES cycles before the next round_rst.
- MATCH_END:
  - Outputs are held; win pulses are ignored.
  - ssl_pulse -> next cycle: scores = 0, match_over = 0, banner_en = 0, first_player = 0, round_rst pulses, state = ROUND.
- Score arithmetic: saturating at 2^SCORE_W-1. This cannot occur when WIN_TARGET is in range.
- round_rst: never high for two consecutive cycles.
- Reset mid-round: all state is cleared. round_rst is not issued by reset itself; the game core receives the shared reset.

Optional Feature:
- Macro: MATCH_TIMEOUT_EN.
- Defined:
  - A timeout counter is cleared on every round_rst and increments in ROUND.
  - Reaching ROUND_TIMEOUT-1 with no win -> the round is voided: no score change, first_player toggles, round_rst pulses, state stays ROUND.
  - A win pulse on the same cycle as timeout has priority over the timeout.
- Undefined: no timeout counter is present; rounds last indefinitely.

Test Plan:
All scenarios use WIN_TARGET = 2, HOLD_CYCLES = 4.
- Reset then ssl_pulse at cycle 10 -> round_rst high only at cycle 11; state ROUND; first_player = 0.
- In ROUND, p1_win at cycle 20 -> p1_score = 1 and banner_en = 1 at 21; banner_en low and round_rst pulse at 25; first_player = 1.
- p1_win and p2_win together in ROUND -> scores unchanged, no banner, state still ROUND. Win pulses during IDLE or ROUND_END -> ignored.
- Play P2, P1, P2 wins -> after the third hold: match_over = 1, match_winner = 1, p2_score = 2. Then ssl_pulse -> scores 0, round_rst pulse, first_player = 0.
- Assert reset during ROUND_END with p1_score = 1 -> next cycle all outputs at reset values, state IDLE.
- With MATCH_TIMEOUT_EN and ROUND_TIMEOUT = 8: no wins -> round_rst 8 cycles after the previous round_rst, scores unchanged, first_player toggles. Win on the timeout cycle -> scored normally.

Source files
------------

// File: rtl/match_sequencer.sv
// Bulls & Cows round/match controller: round restarts, setter alternation, scores, banner, match end.
// Latency: every output is registered and responds one cycle after the input pulse that causes it.
// Backpressure: none; pulses arriving in states that do not use them are dropped. Optional MATCH_TIMEOUT_EN.
module match_sequencer #(
  parameter int WIN_TARGET  = 3,
  parameter int HOLD_CYCLES = 100000000,
`ifdef MATCH_TIMEOUT_EN
  parameter longint unsigned ROUND_TIMEOUT = 64'd3000000000,
`endif
  parameter int SCORE_W     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ssl_pulse,
  input  logic               p1_win,
  input  logic               p2_win,
  output logic               round_rst,
  output logic               first_player,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               banner_en,
  output logic               round_winner,
  output logic               match_over,
  output logic               match_winner
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] TARGET    = SCORE_W'(WIN_TARGET);

  typedef enum logic [1:0] {IDLE, ROUND, ROUND_END, MATCH_END} state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                rst_d, first_d, banner_d, winner_d, over_d, mwin_d;
  logic [SCORE_W-1:0]  p1_d, p2_d, won_score;

`ifdef MATCH_TIMEOUT_EN
  localparam int TO_W = (ROUND_TIMEOUT > 1) ? $clog2(ROUND_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ROUND_TIMEOUT - 1);
  logic [TO_W-1:0] to_q, to_d;
`endif

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rst_d     = 1'b0;
    first_d   = first_player;
    p1_d      = p1_score;
    p2_d      = p2_score;
    banner_d  = banner_en;
    winner_d  = round_winner;
    over_d    = match_over;
    mwin_d    = match_winner;
    won_score = round_winner ? p2_score : p1_score;

    case (state_q)
      IDLE: begin
        if (ssl_pulse) begin
          rst_d   = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        // Simultaneous wins void the round; a single win beats a same-cycle timeout.
        if (p1_win ^ p2_win) begin
          winner_d = p2_win;
          banner_d = 1'b1;
          hold_d   = HOLD_LOAD;
          state_d  = ROUND_END;
          if (p1_win && p1_score != SCORE_MAX) p1_d = p1_score + 1'b1;
          if (p2_win && p2_score != SCORE_MAX) p2_d = p2_score + 1'b1;
        end
`ifdef MATCH_TIMEOUT_EN
        else if (to_q == TO_LAST && !round_rst) begin
          rst_d   = 1'b1;
          first_d = ~first_player;
        end
`endif
      end
      ROUND_END: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (won_score == TARGET) begin
          over_d  = 1'b1;
          mwin_d  = round_winner;
          state_d = MATCH_END;
        end else begin
          banner_d = 1'b0;
          first_d  = ~first_player;
          rst_d    = 1'b1;
          state_d  = ROUND;
        end
      end
      MATCH_END: begin
        if (ssl_pulse) begin
          p1_d     = '0;
          p2_d     = '0;
          over_d   = 1'b0;
          banner_d = 1'b0;
          first_d  = 1'b0;
          rst_d    = 1'b1;
          state_d  = ROUND;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef MATCH_TIMEOUT_EN
    to_d = to_q;
    if (rst_d)                to_d = '0;
    else if (state_q == ROUND) to_d = to_q + 1'b1;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      round_rst    <= 1'b0;
      first_player <= 1'b0;
      p1_score     <= '0;
      p2_score     <= '0;
      banner_en    <= 1'b0;
      round_winner <= 1'b0;
      match_over   <= 1'b0;
      match_winner <= 1'b0;
`ifdef MATCH_TIMEOUT_EN
      to_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      round_rst    <= rst_d;
      first_player <= first_d;
      p1_score     <= p1_d;
      p2_score     <= p2_d;
      banner_en    <= banner_d;
      round_winner <= winner_d;
      match_over   <= over_d;
      match_winner <= mwin_d;
`ifdef MATCH_TIMEOUT_EN
      to_q         <= to_d;
`endif
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: directed vector table, timeout corner sequence, randomized run against a reference model.
module tb_match_sequencer;
  localparam int WT = 2;
  localparam int HC = 4;
  localparam int SW = 4;
  localparam int RT = 8;

  logic clock = 1'b0;
  logic reset, ssl_pulse, p1_win, p2_win;
  logic round_rst, first_player, banner_en, round_winner, match_over, match_winner;
  logic [SW-1:0] p1_score, p2_score;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  match_sequencer #(
    .WIN_TARGET(WT),
    .HOLD_CYCLES(HC),
`ifdef MATCH_TIMEOUT_EN
    .ROUND_TIMEOUT(64'd8),
`endif
    .SCORE_W(SW)
  ) dut (
    .clock(clock), .reset(reset), .ssl_pulse(ssl_pulse), .p1_win(p1_win), .p2_win(p2_win),
    .round_rst(round_rst), .first_player(first_player), .p1_score(p1_score), .p2_score(p2_score),
    .banner_en(banner_en), .round_winner(round_winner), .match_over(match_over), .match_winner(match_winner)
  );

  // Reference model: game phase, banner age in cycles, and cycle of the most recent round restart.
  localparam int PH_IDLE = 0, PH_PLAY = 1, PH_BANNER = 2, PH_OVER = 3;
  int m_phase, m_age, cyc, last_rr;
  int m_score[2];
  bit m_rr, m_fp, m_ban, m_rw, m_mo, m_mw;
  bit prev_rr;

  task automatic model_edge(input bit rs, input bit ssl, input bit w1, input bit w2);
    cyc++;
    m_rr = 1'b0;
    if (rs) begin
      m_phase = PH_IDLE; m_age = 0; m_score[0] = 0; m_score[1] = 0;
      m_fp = 0; m_ban = 0; m_rw = 0; m_mo = 0; m_mw = 0;
    end else begin
      case (m_phase)
        PH_IDLE: if (ssl) begin m_rr = 1; m_phase = PH_PLAY; end
        PH_PLAY: begin
          if (w1 != w2) begin
            m_rw = w2;
            if (m_score[m_rw] < (1 << SW) - 1) m_score[m_rw]++;
            m_ban = 1; m_age = 1; m_phase = PH_BANNER;
          end
`ifdef MATCH_TIMEOUT_EN
          else if (cyc - last_rr == RT) begin
            m_rr = 1; m_fp = !m_fp;
          end
`endif
        end
        PH_BANNER: begin
          if (m_age < HC) m_age++;
          else if (m_score[m_rw] == WT) begin m_mo = 1; m_mw = m_rw; m_phase = PH_OVER; end
          else begin m_ban = 0; m_fp = !m_fp; m_rr = 1; m_phase = PH_PLAY; end
        end
        default: if (ssl) begin
          m_score[0] = 0; m_score[1] = 0; m_mo = 0; m_ban = 0; m_fp = 0; m_rr = 1; m_phase = PH_PLAY;
        end
      endcase
    end
    if (m_rr) last_rr = cyc;
  endtask

  task automatic step(input bit rs, input bit ssl, input bit w1, input bit w2);
    reset = rs; ssl_pulse = ssl; p1_win = w1; p2_win = w2;
    @(posedge clock);
    model_edge(rs, ssl, w1, w2);
    #1;
  endtask

  // round_winner / match_winner are only compared while their qualifying flag is expected high.
  task automatic check(input string name, input bit rr, input bit fp, input int s1, input int s2,
                       input bit ban, input bit rw, input bit mo, input bit mw);
    bit ok;
    compared++;
    ok = (round_rst === rr) && (first_player === fp) && (p1_score === SW'(s1)) && (p2_score === SW'(s2))
      && (banner_en === ban) && (match_over === mo)
      && (!ban || round_winner === rw) && (!mo || match_winner === mw)
      && !(round_rst === 1'b1 && prev_rr);
    prev_rr = (round_rst === 1'b1);
    if (!ok) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got rr=%b fp=%b s1=%0d s2=%0d ban=%b rw=%b mo=%b mw=%b want rr=%b fp=%b s1=%0d s2=%0d ban=%b rw=%b mo=%b mw=%b",
               name, cyc, round_rst, first_player, p1_score, p2_score, banner_en, round_winner, match_over, match_winner,
               rr, fp, s1, s2, ban, rw, mo, mw);
    end
  endtask

  typedef struct { bit rs, ssl, w1, w2, rr, fp; int s1, s2; bit ban, rw, mo, mw; } vec_t;
  vec_t tbl[$];

  initial begin
    reset = 1; ssl_pulse = 0; p1_win = 0; p2_win = 0;
    cyc = -1; last_rr = 0; prev_rr = 0;
    //                rs ssl w1 w2 | rr fp s1 s2 ban rw mo mw
    tbl.push_back('{1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0}); // 0 reset
    tbl.push_back('{0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0}); // 1 win ignored in idle
    tbl.push_back('{0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0}); // 2 start
    tbl.push_back('{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0}); // 4 double win void
    tbl.push_back('{0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0}); // 5 ssl ignored in round
    tbl.push_back('{0, 0, 1, 0,  0, 0, 1, 0, 1, 0, 0, 0}); // 6 p1 wins
    tbl.push_back('{0, 0, 0, 1,  0, 0, 1, 0, 1, 0, 0, 0}); // 7 win ignored in banner
    tbl.push_back('{0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0}); // 10 next round, setter toggles
    tbl.push_back('{0, 0, 0, 1,  0, 1, 1, 1, 1, 1, 0, 0}); // 11 p2 wins
    tbl.push_back('{0, 0, 0, 0,  0, 1, 1, 1, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0,  0, 1, 1, 1, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0,  0, 1, 1, 1, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0,  1, 0, 1, 1, 0, 1, 0, 0}); // 15
    tbl.push_back('{0, 0, 0, 1,  0, 0, 1, 2, 1, 1, 0, 0}); // 16 p2 reaches target
    tbl.push_back('{0, 1, 0, 0,  0, 0, 1, 2, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0,  0, 0, 1, 2, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0,  0, 0, 1, 2, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0,  0, 0, 1, 2, 1, 1, 1, 1}); // 20 match over, p2
    tbl.push_back('{0, 0, 1, 0,  0, 0, 1, 2, 1, 1, 1, 1}); // 21 win ignored
    tbl.push_back('{0, 1, 0, 0,  1, 0, 0, 0, 0, 1, 0, 1}); // 22 new match
    tbl.push_back('{0, 0, 1, 0,  0, 0, 1, 0, 1, 0, 0, 1}); // 23
    tbl.push_back('{1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0}); // 24 reset in banner
    tbl.push_back('{0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0}); // 25
    tbl.push_back('{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0}); // 26

    @(negedge clock);
    foreach (tbl[i]) begin
      step(tbl[i].rs, tbl[i].ssl, tbl[i].w1, tbl[i].w2);
      check($sformatf("vec%0d", i), tbl[i].rr, tbl[i].fp, tbl[i].s1, tbl[i].s2,
            tbl[i].ban, tbl[i].rw, tbl[i].mo, tbl[i].mw);
    end

`ifdef MATCH_TIMEOUT_EN
    // Restart at cycle 25: timeout restart lands 8 cycles later, then a win on the next timeout cycle scores.
    for (int k = 1; k <= 7; k++) begin
      step(0, 0, 0, 0);
      check("timeout_void", (k == 7), (k == 7), 0, 0, 0, 0, 0, 0);
    end
    for (int k = 1; k <= 7; k++) begin
      step(0, 0, 0, 0);
      check("timeout_wait", 0, 1, 0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 1, 0);
    check("timeout_win", 0, 1, 1, 0, 1, 0, 0, 0);
`else
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 0, 0);
      check("no_timeout", 0, 0, 0, 0, 0, 0, 0, 0);
    end
`endif

    step(1, 0, 0, 0);
    check("rand_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      bit rs, ssl, w1, w2;
      rs  = ($urandom_range(0, 299) == 0);
      ssl = ($urandom_range(0, 3) == 0);
      w1  = ($urandom_range(0, 5) == 0);
      w2  = ($urandom_range(0, 5) == 0);
      step(rs, ssl, w1, w2);
      check("rand", m_rr, m_fp, m_score[0], m_score[1], m_ban, m_rw, m_mo, m_mw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
